// File: rtl/reaction_timer_core.sv
// Reaction-timer control core: random delay, "go" LED, then a 4-digit BCD ms count
// until the react button is pressed, with early-press and timeout reporting.
module reaction_timer_core #(
  parameter int          MIN_DELAY = 1000,
  parameter int          RAND_BITS = 11,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_btn,
  input  logic       react_btn,
  output logic       led_go,
  output logic       result_valid,
  output logic       early,
  output logic       timeout,
  output logic [3:0] bcd3,
  output logic [3:0] bcd2,
  output logic [3:0] bcd1,
  output logic [3:0] bcd0
);

  localparam int DW = $clog2(MIN_DELAY + (1 << RAND_BITS));

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_GO,
    S_DONE,
    S_EARLY
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              start_s1_q, start_s2_q, start_p_q;
  logic              react_s1_q, react_s2_q, react_p_q;
  logic [DW-1:0]     delay_cnt_q, delay_cnt_d;
  logic [3:0][3:0]   digit_q, digit_d;
  logic              led_go_q, led_go_d;
  logic              result_valid_q, result_valid_d;
  logic              early_q, early_d;
  logic              timeout_q, timeout_d;

  logic              start_edge, react_edge, arm, all_nines;
  logic [3:0][3:0]   digit_inc;
  logic [DW-1:0]     load_val;

  function automatic logic [3:0][3:0] bcd_inc(input logic [3:0][3:0] v);
    logic [3:0][3:0] r;
    logic            carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i] == 4'd9) begin
          r[i] = 4'd0;
        end else begin
          r[i]  = v[i] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    start_edge     = start_s2_q & ~start_p_q;
    react_edge     = react_s2_q & ~react_p_q;
    lfsr_d         = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    all_nines      = (digit_q == 16'h9999);
    digit_inc      = bcd_inc(digit_q);
    load_val       = DW'(MIN_DELAY) + DW'(lfsr_q[RAND_BITS-1:0]);
    arm            = 1'b0;
    state_d        = state_q;
    delay_cnt_d    = delay_cnt_q;
    digit_d        = digit_q;
    led_go_d       = led_go_q;
    result_valid_d = result_valid_q;
    early_d        = early_q;
    timeout_d      = timeout_q;

    case (state_q)
      S_IDLE, S_DONE, S_EARLY: arm = start_edge;
      S_WAIT: begin
        // A press during the wait beats an expiry landing in the same cycle.
        if (react_edge) begin
          state_d = S_EARLY;
          early_d = 1'b1;
        end else if (delay_cnt_q == DW'(1)) begin
          state_d  = S_GO;
          led_go_d = 1'b1;
        end else begin
          delay_cnt_d = delay_cnt_q - DW'(1);
        end
      end
      S_GO: begin
        if (react_edge) begin
          state_d        = S_DONE;
          led_go_d       = 1'b0;
          result_valid_d = 1'b1;
        end else if (all_nines) begin
          state_d        = S_DONE;
          led_go_d       = 1'b0;
          result_valid_d = 1'b1;
          timeout_d      = 1'b1;
        end else begin
          digit_d = digit_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (arm) begin
      state_d        = S_WAIT;
      delay_cnt_d    = load_val;
      digit_d        = '0;
      led_go_d       = 1'b0;
      result_valid_d = 1'b0;
      early_d        = 1'b0;
      timeout_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      lfsr_q         <= LFSR_SEED;
      start_s1_q     <= 1'b0;
      start_s2_q     <= 1'b0;
      start_p_q      <= 1'b0;
      react_s1_q     <= 1'b0;
      react_s2_q     <= 1'b0;
      react_p_q      <= 1'b0;
      delay_cnt_q    <= '0;
      digit_q        <= '0;
      led_go_q       <= 1'b0;
      result_valid_q <= 1'b0;
      early_q        <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      start_s1_q     <= start_btn;
      start_s2_q     <= start_s1_q;
      start_p_q      <= start_s2_q;
      react_s1_q     <= react_btn;
      react_s2_q     <= react_s1_q;
      react_p_q      <= react_s2_q;
      delay_cnt_q    <= delay_cnt_d;
      digit_q        <= digit_d;
      led_go_q       <= led_go_d;
      result_valid_q <= result_valid_d;
      early_q        <= early_d;
      timeout_q      <= timeout_d;
    end
  end

  assign led_go       = led_go_q;
  assign result_valid = result_valid_q;
  assign early        = early_q;
  assign timeout      = timeout_q;
  assign bcd3         = digit_q[3];
  assign bcd2         = digit_q[2];
  assign bcd1         = digit_q[1];
  assign bcd0         = digit_q[0];

endmodule

// File: tb/tb_reaction_timer_core.sv
// Bench for reaction_timer_core: cycle-level behavioural model compared every cycle,
// plus directed scenarios with hand-computed result digits.
module tb_reaction_timer_core;

  localparam int          MIN_DELAY = 1000;
  localparam int          RAND_BITS = 11;
  localparam logic [15:0] SEED      = 16'hACE1;

  logic       clk = 1'b0;
  logic       reset_n, start_btn, react_btn;
  logic       led_go, result_valid, early, timeout;
  logic [3:0] bcd3, bcd2, bcd1, bcd0;

  always #5 clk = ~clk;

  reaction_timer_core #(
    .MIN_DELAY(MIN_DELAY), .RAND_BITS(RAND_BITS), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_btn(start_btn), .react_btn(react_btn),
    .led_go(led_go), .result_valid(result_valid), .early(early), .timeout(timeout),
    .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0)
  );

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  // Model: the result is an integer ms count; pin histories give the edge timing.
  logic [15:0] m_lfsr = SEED;
  bit   [2:0]  m_sh = '0, m_rh = '0;
  int          m_wait_left = 0, m_count = 0;
  bit          m_led = 0, m_valid = 0, m_early = 0, m_timeout = 0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic fb;
    fb = v[0] ^ v[2] ^ v[3] ^ v[5];
    return {fb, v[15:1]};
  endfunction

  function automatic logic [19:0] outs();
    return {led_go, result_valid, early, timeout, bcd3, bcd2, bcd1, bcd0};
  endfunction

  function automatic logic [19:0] model_outs();
    logic [3:0] d3, d2, d1, d0;
    d3 = 4'(m_count / 1000);
    d2 = 4'((m_count / 100) % 10);
    d1 = 4'((m_count / 10) % 10);
    d0 = 4'(m_count % 10);
    return {m_led, m_valid, m_early, m_timeout, d3, d2, d1, d0};
  endfunction

  always @(posedge clk) begin
    bit s_edge, r_edge;
    if (!reset_n) begin
      m_lfsr = SEED; m_sh = '0; m_rh = '0;
      m_wait_left = 0; m_count = 0;
      m_led = 0; m_valid = 0; m_early = 0; m_timeout = 0;
    end else begin
      s_edge = m_sh[1] & ~m_sh[2];
      r_edge = m_rh[1] & ~m_rh[2];
      m_sh = {m_sh[1:0], start_btn};
      m_rh = {m_rh[1:0], react_btn};
      if (m_wait_left > 0) begin
        if (r_edge) begin
          m_early = 1; m_wait_left = 0;
        end else if (m_wait_left == 1) begin
          m_wait_left = 0; m_led = 1;
        end else begin
          m_wait_left--;
        end
      end else if (m_led) begin
        if (r_edge) begin
          m_led = 0; m_valid = 1;
        end else if (m_count == 9999) begin
          m_led = 0; m_valid = 1; m_timeout = 1;
        end else begin
          m_count++;
        end
      end else if (s_edge) begin
        m_wait_left = MIN_DELAY + int'(m_lfsr & 16'((1 << RAND_BITS) - 1));
        m_count = 0; m_valid = 0; m_early = 0; m_timeout = 0;
      end
      m_lfsr = lfsr_next(m_lfsr);
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checks++;
      if (outs() !== model_outs()) begin
        errors++;
        $display("FAIL model_cmp t=%0t got=%h exp=%h", $time, outs(), model_outs());
      end
    end
  end

  task automatic check(input string name, input logic [19:0] got, input logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_start(input int n);
    start_btn = 1'b1;
    tick(n);
    start_btn = 1'b0;
  endtask

  task automatic wait_led(input int bound);
    int n = 0;
    while (led_go !== 1'b1 && n < bound) begin tick(1); n++; end
  endtask

  task automatic wait_valid(input int bound);
    int n = 0;
    while (result_valid !== 1'b1 && n < bound) begin tick(1); n++; end
  endtask

  task automatic wait_early(input logic level, input int bound);
    int n = 0;
    while (early !== level && n < bound) begin tick(1); n++; end
  endtask

  task automatic wait_digits(input logic [15:0] v, input int bound);
    int n = 0;
    while ({bcd3, bcd2, bcd1, bcd0} !== v && n < bound) begin tick(1); n++; end
  endtask

  initial begin
    reset_n = 1'b0; start_btn = 1'b1; react_btn = 1'b1;
    tick(1);
    check_en = 1'b1;
    tick(2);
    check("reset_hold", outs(), 20'h0_0000);
    start_btn = 1'b0; react_btn = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(10);
    check("post_reset_idle", outs(), 20'h0_0000);

    // Normal run: react edge seen in the 251st GO cycle.
    press_start(5);
    wait_led(4000);
    check("go_rise", outs(), 20'h8_0000);
    tick(248);
    react_btn = 1'b1;
    wait_valid(20);
    check("normal_result", outs(), 20'h4_0250);
    tick(3); react_btn = 1'b0; tick(3);

    // Early press, then re-arm while react stays held.
    press_start(2);
    tick(100);
    react_btn = 1'b1;
    wait_early(1'b1, 20);
    check("early", outs(), 20'h2_0000);
    press_start(2);
    wait_early(1'b0, 20);
    check("rearm_clear", outs(), 20'h0_0000);

    // Timeout run (react still held, so no fresh edge).
    wait_led(4000);
    wait_digits(16'h0999, 1100);
    tick(1);
    check("carry_0999_1000", outs(), 20'h8_1000);
    wait_valid(10000);
    check("timeout", outs(), 20'h5_9999);
    react_btn = 1'b0; tick(3);

    // React edge lands in the cycle showing 9999.
    press_start(2);
    wait_led(4000);
    tick(9997);
    react_btn = 1'b1;
    wait_valid(20);
    check("react_at_9999", outs(), 20'h4_9999);
    react_btn = 1'b0; tick(3);

    // Start and react edges in the same GO cycle.
    press_start(2);
    wait_led(4000);
    tick(10);
    start_btn = 1'b1; react_btn = 1'b1;
    wait_valid(20);
    check("start_react_same", outs(), 20'h4_0012);
    tick(5);
    check("start_ignored_hold", outs(), 20'h4_0012);
    start_btn = 1'b0; react_btn = 1'b0; tick(3);

    // Reset in the middle of GO, then a fresh run.
    press_start(2);
    wait_led(4000);
    wait_digits(16'h0042, 100);
    check("reach_0042", outs(), 20'h8_0042);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check("mid_go_reset", outs(), 20'h0_0000);
    tick(5);
    check("after_reset_idle", outs(), 20'h0_0000);
    press_start(2);
    wait_led(4000);
    tick(5);
    react_btn = 1'b1;
    wait_valid(20);
    check("fresh_run", outs(), 20'h4_0007);
    react_btn = 1'b0; tick(3);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
